// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 68000 bus cycle sequencer behind the MMU.
// Decodes the physical page into a region select, inserts per-region
// wait states and ends each cycle with DTACK or BERR.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   as_n, rw      : CPU address strobe (synchronised) and read/write
//   addr_in       : physical page [27:12] from the MMU
//   io_ready      : primary I/O device ready
//   mmu_enable    : MMU translation enable
//   *_cs          : active-high region selects
//   oe, we        : read / write strobes to the selected device
//   dtack_n       : data transfer acknowledge, active-low
//   berr_n        : bus error, active-low
module bus_cycle_ctrl #(
    parameter logic [3:0] RAM_WAIT = 4'd0,
    parameter logic [3:0] ROM_WAIT = 4'd1,
    parameter logic [3:0] GFX_WAIT = 4'd2,
    parameter logic [3:0] IO_WAIT  = 4'd1,
    parameter logic [7:0] TIMEOUT  = 8'd64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         as_n,
    input  logic         rw,
    input  logic [27:12] addr_in,
    input  logic         io_ready,
    output logic         mmu_enable,
    output logic         ram_cs,
    output logic         rom_cs,
    output logic         gfx_cs,
    output logic         io_cs,
    output logic         board_cs,
    output logic         ptab_cs,
    output logic         oe,
    output logic         we,
    output logic         dtack_n,
    output logic         berr_n
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT,
        ACK,
        ERR
    } state_t;

    // One-hot select order: {ram, rom, gfx, io, board, ptab}
    localparam logic [5:0] CS_RAM   = 6'b100000;
    localparam logic [5:0] CS_ROM   = 6'b010000;
    localparam logic [5:0] CS_GFX   = 6'b001000;
    localparam logic [5:0] CS_IO    = 6'b000100;
    localparam logic [5:0] CS_BOARD = 6'b000010;
    localparam logic [5:0] CS_PTAB  = 6'b000001;

    state_t     state;
    logic [5:0] cs;
    logic [3:0] wcnt;
    logic [7:0] tcnt;

    logic [5:0] dec_cs;
    logic [3:0] dec_wait;

    always_comb begin
        dec_cs   = 6'b000000;
        dec_wait = 4'd0;
        if (addr_in[27]) begin
            dec_cs   = CS_RAM;
            dec_wait = RAM_WAIT;
        end else if (addr_in[27:26] == 2'b01) begin
            dec_cs   = CS_ROM;
            dec_wait = ROM_WAIT;
        end else if (addr_in[27:22] == 6'b001111) begin
            dec_cs   = CS_GFX;
            dec_wait = GFX_WAIT;
        end else if (addr_in[27:20] == 8'h03) begin
            dec_cs   = CS_IO;
            dec_wait = IO_WAIT;
        end else if (addr_in[27:20] == 8'h02) begin
            dec_cs   = CS_PTAB;
        end else if (addr_in[27:20] == 8'h01) begin
            dec_cs   = CS_BOARD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mmu_enable <= 1'b0;
            cs         <= 6'b000000;
            oe         <= 1'b0;
            we         <= 1'b0;
            dtack_n    <= 1'b1;
            berr_n     <= 1'b1;
            wcnt       <= 4'd0;
            tcnt       <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!as_n) begin
                        state      <= DECODE;
                        mmu_enable <= 1'b1;
                    end
                end
                DECODE: begin
                    if (as_n) begin
                        state      <= IDLE;
                        mmu_enable <= 1'b0;
                    end else if (dec_cs == 6'b000000 ||
                                 (dec_cs == CS_ROM && !rw)) begin
                        state  <= ERR;
                        berr_n <= 1'b0;
                    end else begin
                        state <= WAIT;
                        cs    <= dec_cs;
                        oe    <= rw;
                        we    <= ~rw;
                        wcnt  <= dec_wait;
                        tcnt  <= 8'd0;
                    end
                end
                WAIT: begin
                    if (as_n) begin
                        state      <= IDLE;
                        mmu_enable <= 1'b0;
                        cs         <= 6'b000000;
                        oe         <= 1'b0;
                        we         <= 1'b0;
                    end else if (cs == CS_IO) begin
                        // Ready is checked first so it beats the timeout
                        if (wcnt == 4'd0 && io_ready) begin
                            state   <= ACK;
                            dtack_n <= 1'b0;
                        end else if (tcnt == TIMEOUT - 8'd1) begin
                            state  <= ERR;
                            berr_n <= 1'b0;
                            cs     <= 6'b000000;
                            oe     <= 1'b0;
                            we     <= 1'b0;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                            if (wcnt != 4'd0) begin
                                wcnt <= wcnt - 4'd1;
                            end
                        end
                    end else if (wcnt == 4'd0) begin
                        state   <= ACK;
                        dtack_n <= 1'b0;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ACK, ERR: begin
                    if (as_n) begin
                        state      <= IDLE;
                        mmu_enable <= 1'b0;
                        cs         <= 6'b000000;
                        oe         <= 1'b0;
                        we         <= 1'b0;
                        dtack_n    <= 1'b1;
                        berr_n     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ram_cs   = cs[5];
    assign rom_cs   = cs[4];
    assign gfx_cs   = cs[3];
    assign io_cs    = cs[2];
    assign board_cs = cs[1];
    assign ptab_cs  = cs[0];

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl.
// Inputs change #1 after a rising edge; outputs are checked at that point.
module tb_bus_cycle_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         as_n;
    logic         rw;
    logic [27:12] addr_in;
    logic         io_ready;
    logic         mmu_enable;
    logic         ram_cs, rom_cs, gfx_cs, io_cs, board_cs, ptab_cs;
    logic         oe, we, dtack_n, berr_n;

    int cmp = 0;
    int mis = 0;

    always #5 clk = ~clk;

    bus_cycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .as_n       (as_n),
        .rw         (rw),
        .addr_in    (addr_in),
        .io_ready   (io_ready),
        .mmu_enable (mmu_enable),
        .ram_cs     (ram_cs),
        .rom_cs     (rom_cs),
        .gfx_cs     (gfx_cs),
        .io_cs      (io_cs),
        .board_cs   (board_cs),
        .ptab_cs    (ptab_cs),
        .oe         (oe),
        .we         (we),
        .dtack_n    (dtack_n),
        .berr_n     (berr_n)
    );

    // {mmu_enable, ram, rom, gfx, io, board, ptab, oe, we, dtack_n, berr_n}
    wire [10:0] outs = {mmu_enable, ram_cs, rom_cs, gfx_cs, io_cs,
                        board_cs, ptab_cs, oe, we, dtack_n, berr_n};
    wire [5:0]  csv  = {ram_cs, rom_cs, gfx_cs, io_cs, board_cs, ptab_cs};
    localparam logic [10:0] IDLE_OUTS = 11'b0_000000_00_11;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; as_n = 1'b1; rw = 1'b1;
        addr_in = 16'h0000; io_ready = 1'b0;
        tick(); tick();
        cmp++;
        if (outs !== IDLE_OUTS) begin
            mis++;
            $display("FAIL reset_state: got %b want %b", outs, IDLE_OUTS);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ram_read();
        as_n = 1'b0; rw = 1'b1; addr_in = 16'h8000;
        tick();
        cmp++;
        if (outs !== 11'b1_000000_00_11) begin
            mis++;
            $display("FAIL ram_e0: got %b want %b", outs, 11'b1_000000_00_11);
        end
        tick();
        cmp++;
        if (outs !== 11'b1_100000_10_11) begin
            mis++;
            $display("FAIL ram_e1: got %b want %b", outs, 11'b1_100000_10_11);
        end
        tick();
        cmp++;
        if (outs !== 11'b1_100000_10_01) begin
            mis++;
            $display("FAIL ram_e2: got %b want %b", outs, 11'b1_100000_10_01);
        end
        as_n = 1'b1;
        tick();
        cmp++;
        if (outs !== IDLE_OUTS) begin
            mis++;
            $display("FAIL ram_release: got %b want %b", outs, IDLE_OUTS);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [5:0]  cs;
        int          w;
    } vec_t;

    task automatic test_wait_regions();
        vec_t v[7];
        v[0] = '{16'h3C00, 1'b1, 6'b001000, 2};
        v[1] = '{16'h4000, 1'b1, 6'b010000, 1};
        v[2] = '{16'h0100, 1'b1, 6'b000010, 0};
        v[3] = '{16'h0200, 1'b1, 6'b000001, 0};
        v[4] = '{16'hFFFF, 1'b0, 6'b100000, 0};
        v[5] = '{16'h7FFF, 1'b1, 6'b010000, 1};
        v[6] = '{16'h3FFF, 1'b0, 6'b001000, 2};
        foreach (v[i]) begin
            as_n = 1'b0; rw = v[i].rw; addr_in = v[i].addr;
            tick(); tick();
            cmp++;
            if (csv !== v[i].cs || oe !== v[i].rw || we !== ~v[i].rw) begin
                mis++;
                $display("FAIL region_cs[%0d]: got cs=%b oe=%b we=%b want cs=%b rw=%b",
                         i, csv, oe, we, v[i].cs, v[i].rw);
            end
            for (int k = 0; k < v[i].w; k++) begin
                tick();
                cmp++;
                if (dtack_n !== 1'b1) begin
                    mis++;
                    $display("FAIL region_wait[%0d] k=%0d: dtack_n got %b want 1",
                             i, k, dtack_n);
                end
            end
            tick();
            cmp++;
            if (dtack_n !== 1'b0 || berr_n !== 1'b1 || csv !== v[i].cs) begin
                mis++;
                $display("FAIL region_ack[%0d]: got dtack_n=%b berr_n=%b cs=%b want 0 1 %b",
                         i, dtack_n, berr_n, csv, v[i].cs);
            end
            as_n = 1'b1;
            tick();
            cmp++;
            if (outs !== IDLE_OUTS) begin
                mis++;
                $display("FAIL region_release[%0d]: got %b want %b", i, outs, IDLE_OUTS);
            end
        end
    endtask

    task automatic test_errors();
        logic [15:0] a[6];
        logic        r[6];
        a[0] = 16'h4000; r[0] = 1'b0;
        a[1] = 16'h0000; r[1] = 1'b1;
        a[2] = 16'h1000; r[2] = 1'b1;
        a[3] = 16'h00FF; r[3] = 1'b0;
        a[4] = 16'h0400; r[4] = 1'b1;
        a[5] = 16'h3BFF; r[5] = 1'b1;
        foreach (a[i]) begin
            as_n = 1'b0; rw = r[i]; addr_in = a[i];
            tick(); tick();
            cmp++;
            if (outs !== 11'b1_000000_00_10) begin
                mis++;
                $display("FAIL berr[%0d] addr=%h: got %b want %b",
                         i, a[i], outs, 11'b1_000000_00_10);
            end
            tick();
            cmp++;
            if (berr_n !== 1'b0 || dtack_n !== 1'b1) begin
                mis++;
                $display("FAIL berr_hold[%0d]: got berr_n=%b dtack_n=%b want 0 1",
                         i, berr_n, dtack_n);
            end
            as_n = 1'b1;
            tick();
            cmp++;
            if (outs !== IDLE_OUTS) begin
                mis++;
                $display("FAIL berr_release[%0d]: got %b want %b", i, outs, IDLE_OUTS);
            end
        end
    endtask

    task automatic test_io_ready();
        as_n = 1'b0; rw = 1'b1; addr_in = 16'h0300; io_ready = 1'b0;
        tick(); tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            cmp++;
            if (io_cs !== 1'b1 || dtack_n !== 1'b1 || berr_n !== 1'b1) begin
                mis++;
                $display("FAIL io_hold k=%0d: got io_cs=%b dtack_n=%b berr_n=%b want 1 1 1",
                         k, io_cs, dtack_n, berr_n);
            end
        end
        io_ready = 1'b1;
        tick();
        cmp++;
        if (outs !== 11'b1_000100_10_01) begin
            mis++;
            $display("FAIL io_ack: got %b want %b", outs, 11'b1_000100_10_01);
        end
        io_ready = 1'b0; as_n = 1'b1;
        tick();
        cmp++;
        if (outs !== IDLE_OUTS) begin
            mis++;
            $display("FAIL io_release: got %b want %b", outs, IDLE_OUTS);
        end
    endtask

    task automatic test_io_timeout();
        int early;
        as_n = 1'b0; rw = 1'b0; addr_in = 16'h03FF; io_ready = 1'b0;
        tick(); tick();
        early = 0;
        for (int k = 0; k < 63; k++) begin
            tick();
            if (berr_n !== 1'b1 || io_cs !== 1'b1) early++;
        end
        cmp++;
        if (early != 0) begin
            mis++;
            $display("FAIL io_timeout_early: got %0d bad cycles want 0", early);
        end
        tick();
        cmp++;
        if (outs !== 11'b1_000000_00_10) begin
            mis++;
            $display("FAIL io_timeout: got %b want %b", outs, 11'b1_000000_00_10);
        end
        as_n = 1'b1;
        tick();
        cmp++;
        if (outs !== IDLE_OUTS) begin
            mis++;
            $display("FAIL io_timeout_release: got %b want %b", outs, IDLE_OUTS);
        end
        // ready arriving on the timeout edge must acknowledge
        as_n = 1'b0; rw = 1'b1; addr_in = 16'h0300;
        tick(); tick();
        for (int k = 0; k < 63; k++) tick();
        io_ready = 1'b1;
        tick();
        cmp++;
        if (dtack_n !== 1'b0 || berr_n !== 1'b1 || io_cs !== 1'b1) begin
            mis++;
            $display("FAIL io_race: got dtack_n=%b berr_n=%b io_cs=%b want 0 1 1",
                     dtack_n, berr_n, io_cs);
        end
        io_ready = 1'b0; as_n = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        as_n = 1'b0; rw = 1'b1; addr_in = 16'h3C00;
        tick(); tick();
        as_n = 1'b1;
        tick();
        cmp++;
        if (outs !== IDLE_OUTS) begin
            mis++;
            $display("FAIL abort_wait: got %b want %b", outs, IDLE_OUTS);
        end
        tick(); tick();
        cmp++;
        if (dtack_n !== 1'b1 || berr_n !== 1'b1) begin
            mis++;
            $display("FAIL abort_nopulse: got dtack_n=%b berr_n=%b want 1 1",
                     dtack_n, berr_n);
        end
        as_n = 1'b0; addr_in = 16'h0000;
        tick();
        as_n = 1'b1;
        tick();
        cmp++;
        if (outs !== IDLE_OUTS) begin
            mis++;
            $display("FAIL abort_decode: got %b want %b", outs, IDLE_OUTS);
        end
    endtask

    task automatic test_reset_in_ack();
        as_n = 1'b0; rw = 1'b1; addr_in = 16'h8000;
        tick(); tick(); tick();
        cmp++;
        if (dtack_n !== 1'b0) begin
            mis++;
            $display("FAIL rst_ack_pre: dtack_n got %b want 0", dtack_n);
        end
        reset = 1'b1;
        tick();
        cmp++;
        if (outs !== IDLE_OUTS) begin
            mis++;
            $display("FAIL rst_in_ack: got %b want %b", outs, IDLE_OUTS);
        end
        reset = 1'b0; as_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        as_n = 1'b0; rw = 1'b1; addr_in = 16'h8000;
        tick(); tick(); tick();
        as_n = 1'b1;
        tick();
        cmp++;
        if (outs !== IDLE_OUTS) begin
            mis++;
            $display("FAIL b2b_idle: got %b want %b", outs, IDLE_OUTS);
        end
        as_n = 1'b0; addr_in = 16'h9000;
        tick();
        cmp++;
        if (outs !== 11'b1_000000_00_11) begin
            mis++;
            $display("FAIL b2b_e0: got %b want %b", outs, 11'b1_000000_00_11);
        end
        tick();
        cmp++;
        if (outs !== 11'b1_100000_10_11) begin
            mis++;
            $display("FAIL b2b_e1: got %b want %b", outs, 11'b1_100000_10_11);
        end
        tick();
        cmp++;
        if (outs !== 11'b1_100000_10_01) begin
            mis++;
            $display("FAIL b2b_e2: got %b want %b", outs, 11'b1_100000_10_01);
        end
        as_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_wait_regions();
        test_errors();
        test_io_ready();
        test_io_timeout();
        test_abort();
        test_reset_in_ack();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Downstream consumer of the MMU's translated page address (addr_out[27:12]).
- Sequences each 68000 bus cycle: enables the MMU, decodes the physical page into a region chip select, inserts per-region wait states, and terminates the cycle with DTACK or BERR.
- Sits between the CPU strobes and the RAM/ROM/graphics/I/O/board-control/page-table devices.

Parameters:
- RAM_WAIT, 0, wait cycles for main RAM (4-bit)
- ROM_WAIT, 1, wait cycles for ROM (4-bit)
- GFX_WAIT, 2, wait cycles for graphics/audio RAM (4-bit)
- IO_WAIT, 1, minimum wait cycles for primary I/O before io_ready is honoured (4-bit)
- TIMEOUT, 64, cycles in WAIT for a primary I/O access before BERR (8-bit, must be > IO_WAIT)

Ports:
- clk input 1 system clock; all logic on rising edge
- reset input 1 synchronous, active-high
- as_n input 1 CPU address strobe, already synchronised to clk
- rw input 1 CPU read(1)/write(0)
- addr_in input [27:12] physical page from MMU addr_out
- io_ready input 1 primary I/O device ready
- mmu_enable output 1 drives MMU enable
- ram_cs, rom_cs, gfx_cs, io_cs, board_cs, ptab_cs output 1 each, region selects, active-high
- oe output 1 read strobe to selected device
- we output 1 write strobe to selected device
- dtack_n output 1 data transfer acknowledge, active-low
- berr_n output 1 bus error, active-low

Behaviour:
- Reset (synchronous, active-high; applies mid-cycle as well): state IDLE; mmu_enable=0, all cs=0, oe=0, we=0, dtack_n=1, berr_n=1; counters cleared.
- All outputs are registered.
- Region decode is on the full addr_in[27:12]:
  - 8000-FFFF RAM
  - 4000-7FFF ROM
  - 3C00-3FFF GFX
  - 0300-03FF IO
  - 0200-02FF PTAB
  - 0100-01FF BOARD
  - all other values (0000-00FF, 0400-3BFF) unmapped.
- BOARD and PTAB have a fixed 0 wait.
- States: IDLE, DECODE, WAIT, ACK, ERR.
  - IDLE: as_n=0 sampled -> DECODE, mmu_enable=1.
  - DECODE: addr_in sampled here, since the MMU is combinational off mmu_enable.
    - Unmapped, or ROM with rw=0 -> ERR: berr_n=0, no cs.
    - Otherwise -> WAIT: region cs=1, oe=rw, we=~rw; wait counter loaded with region wait; timeout counter cleared.
  - WAIT, non-IO regions: counter==0 -> ACK with dtack_n=0; else decrement.
  - WAIT, IO region:
    - ACK when counter==0 and io_ready=1.
    - Timeout counter increments every WAIT cycle; reaching TIMEOUT -> ERR: berr_n=0, cs/oe/we dropped.
    - If the ready and timeout conditions hit on the same edge, ACK wins.
  - ACK/ERR: hold all outputs until as_n=1 sampled -> IDLE; all outputs deassert on that same edge.
- Abort: as_n=1 sampled in DECODE or WAIT -> IDLE, all outputs inactive, no dtack/berr pulse.
- Back-to-back cycles: IDLE always spends at least one cycle, so a new as_n=0 is sampled no earlier than the edge after return to IDLE.
- Latency, as_n low sampled at edge E0, wait W:
  - mmu_enable after E0
  - cs after E0+1
  - dtack_n low after E0+2+W
- dtack_n and berr_n are never low simultaneously.
- At most one cs is high at a time.
- mmu_enable stays high from DECODE through ACK/ERR.

Test Plan:
- Reset held 2 cycles, then as_n=0, rw=1, addr_in=8000 -> mmu_enable high after E0, ram_cs=1 and oe=1 after E0+1, dtack_n=0 after E0+2; as_n=1 -> all outputs idle the next edge.
- as_n=0, rw=1, addr_in=3C00 (GFX_WAIT=2) -> gfx_cs after E0+1, dtack_n low exactly after E0+4; ROM 4000 read -> dtack_n after E0+3; 0100 and 0200 -> board_cs/ptab_cs with dtack_n after E0+2.
- as_n=0, rw=0, addr_in=4000 -> berr_n=0 after E0+1, rom_cs=0, we=0; addr_in=0000 or 1000 -> berr_n=0 after E0+1, no cs.
- addr_in=0300, io_ready=0 for 10 cycles then 1 -> io_cs held, dtack_n low the edge after io_ready sampled; io_ready never high -> berr_n=0 after exactly TIMEOUT=64 WAIT cycles, io_cs dropped.
- as_n returned high during WAIT on 3C00 -> IDLE next edge, dtack_n and berr_n stay 1; reset asserted during ACK -> all outputs inactive after that edge.
- Back-to-back: RAM cycle completes and as_n is low again one cycle after release -> second cycle is sampled no earlier than the edge after IDLE, with full timing repeated.
